// File: rtl/mem_loader_19bit_if.sv
// Byte-stream input and memory-write/status bundle for the program loader.
// The loader sits on the slave side; the byte source and memory/CPU observer on the master side.
interface mem_loader_19bit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 19
);
  logic [7:0]        IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DATA;
  logic              MEM_WR;
  logic              CPU_HOLD;
  logic              LOAD_DONE;
  logic              LOAD_ERR;
  logic [ADDR_W-1:0] WORDS_WRITTEN;

  modport slave (
    input  IN_DATA, IN_VALID,
    output IN_READY, MEM_ADDR, MEM_DATA, MEM_WR,
    output CPU_HOLD, LOAD_DONE, LOAD_ERR, WORDS_WRITTEN
  );

  modport master (
    output IN_DATA, IN_VALID,
    input  IN_READY, MEM_ADDR, MEM_DATA, MEM_WR,
    input  CPU_HOLD, LOAD_DONE, LOAD_ERR, WORDS_WRITTEN
  );
endinterface

// File: rtl/mem_loader_19bit.sv
// Framed byte-serial loader into the 4K x 19 main memory; MEM_WR fires the cycle after each B2 byte.
// IN_READY is a Moore output of the FSM and drops only in the WRITE and DONE cycles.
module mem_loader_19bit #(
  parameter int         ADDR_W    = 12,
  parameter int         DATA_W    = 19,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic               CLK,
  input logic               RST,
  mem_loader_19bit_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, A_LO, A_HI, C_LO, C_HI, W0, W1, W2, WRITE, CHK, DONE
  } state_t;

  state_t            state, nxt_state;
  logic              acc;
  logic              in_ready, mem_wr, cpu_hold, load_done;
  logic [ADDR_W-1:0] addr, cnt, cnt_next, wr_addr, words;
  logic [DATA_W-1:0] wr_data;
  logic [7:0]        csum, b0, b1;
  logic              load_err;

  assign acc      = bus.IN_VALID && in_ready;
  assign cnt_next = ADDR_W'({bus.IN_DATA, cnt[7:0]});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:  if (acc && bus.IN_DATA == SYNC_BYTE) nxt_state = A_LO;
      A_LO:  if (acc) nxt_state = A_HI;
      A_HI:  if (acc) nxt_state = C_LO;
      C_LO:  if (acc) nxt_state = C_HI;
      C_HI:  if (acc) nxt_state = (cnt_next != '0) ? W0 : CHK;
      W0:    if (acc) nxt_state = W1;
      W1:    if (acc) nxt_state = W2;
      W2:    if (acc) nxt_state = WRITE;
      // cnt still includes the word being written this cycle
      WRITE: nxt_state = (cnt > ADDR_W'(1)) ? W0 : CHK;
      CHK:   if (acc) nxt_state = (bus.IN_DATA == csum) ? DONE : IDLE;
      DONE:  nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_wr    = 1'b0;
    cpu_hold  = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      A_LO, A_HI, C_LO, C_HI, W0, W1, W2, CHK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      WRITE: begin
        mem_wr   = 1'b1;
        cpu_hold = 1'b1;
      end
      DONE: load_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr     <= '0;
      cnt      <= '0;
      csum     <= '0;
      b0       <= '0;
      b1       <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      words    <= '0;
      load_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc && bus.IN_DATA == SYNC_BYTE) begin
          csum     <= '0;
          words    <= '0;
          load_err <= 1'b0;
        end
        A_LO: if (acc) addr <= ADDR_W'(bus.IN_DATA);
        A_HI: if (acc) addr <= ADDR_W'({bus.IN_DATA, addr[7:0]});
        C_LO: if (acc) cnt <= ADDR_W'(bus.IN_DATA);
        C_HI: if (acc) cnt <= cnt_next;
        W0:   if (acc) b0 <= bus.IN_DATA;
        W1:   if (acc) b1 <= bus.IN_DATA;
        // latch the write port here so it stays put after addr advances
        W2: if (acc) begin
          wr_addr <= addr;
          wr_data <= DATA_W'({bus.IN_DATA, b1, b0});
        end
        WRITE: begin
          addr  <= addr + ADDR_W'(1);
          words <= words + ADDR_W'(1);
          cnt   <= cnt - ADDR_W'(1);
        end
        CHK: if (acc && bus.IN_DATA != csum) load_err <= 1'b1;
        default: ;
      endcase

      if (acc && state inside {A_LO, A_HI, C_LO, C_HI, W0, W1, W2})
        csum <= csum ^ bus.IN_DATA;
    end
  end

  assign bus.IN_READY      = in_ready;
  assign bus.MEM_WR        = mem_wr;
  assign bus.CPU_HOLD      = cpu_hold;
  assign bus.LOAD_DONE     = load_done;
  assign bus.MEM_ADDR      = wr_addr;
  assign bus.MEM_DATA      = wr_data;
  assign bus.LOAD_ERR      = load_err;
  assign bus.WORDS_WRITTEN = words;

endmodule

// File: tb/tb_mem_loader_19bit.sv
// Scoreboard bench for mem_loader_19bit: directed frames push expected writes/events,
// a negedge monitor pops and compares whenever the loader writes, finishes or flags an error.
module tb_mem_loader_19bit;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 19;

  logic CLK = 1'b0;
  logic RST;

  mem_loader_19bit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_loader_19bit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic              is_err;
    logic [ADDR_W-1:0] words;
  } ev_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  wr_t        exp_wr[$];
  ev_t        exp_ev[$];
  logic [7:0] frame[$];
  logic       prev_err = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_ev(input logic is_err, input logic [ADDR_W-1:0] words);
    ev_t e;
    e.is_err = is_err;
    e.words  = words;
    exp_ev.push_back(e);
  endtask

  // Monitor: compares every observable loader action against the scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      check("in_ready_only_low_in_write_done", 32'(bus.IN_READY),
            32'(!(bus.MEM_WR || bus.LOAD_DONE)));
      if (bus.MEM_WR) begin
        if (exp_wr.size() == 0) fail("unexpected_mem_wr");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("mem_addr", 32'(bus.MEM_ADDR), 32'(w.addr));
          check("mem_data", 32'(bus.MEM_DATA), 32'(w.data));
          check("hold_during_write", 32'(bus.CPU_HOLD), 32'd1);
        end
      end
      if (bus.LOAD_DONE) begin
        if (exp_ev.size() == 0 || exp_ev[0].is_err) fail("unexpected_load_done");
        else begin
          ev_t e;
          e = exp_ev.pop_front();
          check("done_words_written", 32'(bus.WORDS_WRITTEN), 32'(e.words));
          check("done_load_err", 32'(bus.LOAD_ERR), 32'd0);
          check("done_cpu_hold", 32'(bus.CPU_HOLD), 32'd0);
        end
      end
      if (bus.LOAD_ERR && !prev_err) begin
        if (exp_ev.size() == 0 || !exp_ev[0].is_err) fail("unexpected_load_err");
        else begin
          ev_t e;
          e = exp_ev.pop_front();
          check("err_words_written", 32'(bus.WORDS_WRITTEN), 32'(e.words));
          check("err_cpu_hold", 32'(bus.CPU_HOLD), 32'd0);
        end
      end
    end
    prev_err = bus.LOAD_ERR;
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard;
    bit acc;
    if (rnd) begin
      repeat ($urandom_range(0, 3)) begin
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 8'($urandom);
        @(posedge CLK); #1;
      end
    end
    bus.IN_DATA  = b;
    bus.IN_VALID = 1'b1;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 50) begin
      @(negedge CLK);
      acc = bus.IN_READY;
      @(posedge CLK); #1;
      guard++;
    end
    bus.IN_VALID = 1'b0;
    if (!acc) fail("byte_accept_timeout");
  endtask

  task automatic send_range(input int lo, input int hi, input bit rnd);
    for (int i = lo; i < hi; i++) send_byte(frame[i], rnd);
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && guard < 40) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (exp_wr.size() != 0 || exp_ev.size() != 0) begin
      fail({"missing_output_", name});
      exp_wr.delete();
      exp_ev.delete();
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic load_basic();
    frame = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00,
              8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07, 8'h72};
  endtask

  initial begin
    RST          = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    check("rst_mem_wr", 32'(bus.MEM_WR), 32'd0);
    check("rst_cpu_hold", 32'(bus.CPU_HOLD), 32'd0);
    check("rst_load_done", 32'(bus.LOAD_DONE), 32'd0);
    check("rst_load_err", 32'(bus.LOAD_ERR), 32'd0);
    check("rst_words", 32'(bus.WORDS_WRITTEN), 32'd0);
    check("rst_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
    check("rst_mem_data", 32'(bus.MEM_DATA), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Basic load
    load_basic();
    push_wr(12'h010, 19'h12345);
    push_wr(12'h011, 19'h7FFFF);
    push_ev(1'b0, 12'd2);
    send_range(0, 1, 1'b0);
    check("basic_hold_after_sync", 32'(bus.CPU_HOLD), 32'd1);
    send_range(1, 11, 1'b0);
    check("basic_hold_before_csum", 32'(bus.CPU_HOLD), 32'd1);
    send_range(11, 12, 1'b0);
    wait_drain("basic");
    check("basic_words", 32'(bus.WORDS_WRITTEN), 32'd2);
    check("basic_err", 32'(bus.LOAD_ERR), 32'd0);
    check("basic_addr_hold", 32'(bus.MEM_ADDR), 32'h011);
    check("basic_data_hold", 32'(bus.MEM_DATA), 32'h7FFFF);

    // Address wrap 0xFFF -> 0x000
    frame = '{8'hA5, 8'hFF, 8'h0F, 8'h02, 8'h00,
              8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hF1};
    push_wr(12'hFFF, 19'h00001);
    push_wr(12'h000, 19'h00002);
    push_ev(1'b0, 12'd2);
    send_range(0, frame.size(), 1'b0);
    wait_drain("wrap");

    // Empty frame
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_ev(1'b0, 12'd0);
    send_range(0, frame.size(), 1'b0);
    wait_drain("empty");
    check("empty_words", 32'(bus.WORDS_WRITTEN), 32'd0);

    // Bad checksum, then recovery
    load_basic();
    frame[11] = 8'h73;
    push_wr(12'h010, 19'h12345);
    push_wr(12'h011, 19'h7FFFF);
    push_ev(1'b1, 12'd2);
    send_range(0, frame.size(), 1'b0);
    wait_drain("badcsum");
    repeat (5) @(posedge CLK);
    #1;
    check("err_sticky", 32'(bus.LOAD_ERR), 32'd1);
    check("err_hold_low", 32'(bus.CPU_HOLD), 32'd0);
    load_basic();
    push_wr(12'h010, 19'h12345);
    push_wr(12'h011, 19'h7FFFF);
    push_ev(1'b0, 12'd2);
    send_range(0, 1, 1'b0);
    check("err_cleared_at_sync", 32'(bus.LOAD_ERR), 32'd0);
    send_range(1, frame.size(), 1'b0);
    wait_drain("recover");

    // Backpressure: junk before SYNC and random IN_VALID gaps
    load_basic();
    frame.push_front(8'h5A);
    frame.push_front(8'h00);
    push_wr(12'h010, 19'h12345);
    push_wr(12'h011, 19'h7FFFF);
    push_ev(1'b0, 12'd2);
    send_range(0, frame.size(), 1'b1);
    wait_drain("backpressure");

    // Reset after B1 of the first word
    load_basic();
    send_range(0, 7, 1'b0);
    check("pre_reset_hold", 32'(bus.CPU_HOLD), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("reset_hold_async", 32'(bus.CPU_HOLD), 32'd0);
    check("reset_mem_wr", 32'(bus.MEM_WR), 32'd0);
    check("reset_in_ready", 32'(bus.IN_READY), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    check("reset_words", 32'(bus.WORDS_WRITTEN), 32'd0);

    // Full frame after reset; upper bits of B2 must be dropped
    frame = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'h34, 8'h12, 8'hF9, 8'hFE};
    push_wr(12'h020, 19'h11234);
    push_ev(1'b0, 12'd1);
    send_range(0, frame.size(), 1'b0);
    wait_drain("after_reset");
    check("after_reset_words", 32'(bus.WORDS_WRITTEN), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mem_loader_19bit.md
Name: mem_loader_19bit

Overview:
- Byte-serial program loader that writes into the 4K x 19-bit main memory. It is the write-side counterpart of the CPU's memory fetch path.
- Receives a framed byte stream over a valid/ready handshake and assembles 19-bit words. It issues one memory write per word at consecutive 12-bit addresses.
- Holds the CPU (CPU_HOLD) for the duration of a load and reports completion or checksum failure.

Parameters:
ADDR_W, 12, memory address width (4K words)
DATA_W, 19, memory word width; must be 17..24, packed as 3 bytes per word
SYNC_BYTE, 8'hA5, frame start marker

Ports:
CLK  input  1  system clock, all state changes on rising edge
RST  input  1  asynchronous, active-high reset
IN_DATA  input  8  incoming byte
IN_VALID  input  1  IN_DATA valid
IN_READY  output  1  loader accepts byte; transfer when IN_VALID && IN_READY at rising CLK
MEM_ADDR  output  ADDR_W  write address to memory
MEM_DATA  output  DATA_W  write data to memory
MEM_WR  output  1  one-cycle write strobe; MEM_ADDR/MEM_DATA stable while high
CPU_HOLD  output  1  high from sync accept until DONE/ERR cycle; CPU sequencer must stall
LOAD_DONE  output  1  one-cycle pulse, frame loaded with good checksum
LOAD_ERR  output  1  sticky checksum-fail flag
WORDS_WRITTEN  output  ADDR_W  words written in current/last frame

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. It forces state IDLE and drives every output to 0 except IN_READY=1 (Moore, IDLE). All counters and the checksum are cleared.
- Frame format, little-endian: SYNC, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, N x (B0, B1, B2), CSUM.
- Field widths: only the low ADDR_W bits of the address and of the count are used. Word = {B2,B1,B0}[DATA_W-1:0]; upper bits of B2 are ignored.
- Checksum: CSUM must equal the XOR of every byte after SYNC, excluding CSUM itself.
- States: IDLE, A_LO, A_HI, C_LO, C_HI, W0, W1, W2, WRITE, CHK, DONE.
- IDLE: IN_READY=1. Non-SYNC bytes are discarded. An accepted SYNC moves to A_LO, sets CPU_HOLD, clears LOAD_ERR, the checksum and WORDS_WRITTEN.
- A_LO..C_HI: one accepted byte each, in order. After C_HI: go to W0 if count != 0, otherwise go to CHK.
- W0, W1, W2: accept one byte each. Accepting B2 moves to WRITE.
- WRITE (exactly 1 cycle, IN_READY=0):
  - MEM_WR=1 with the current address and the assembled word.
  - Next cycle: address increments modulo 2^ADDR_W (0xFFF wraps to 0x000) and WORDS_WRITTEN increments.
  - Go to W0 if words remain, otherwise go to CHK.
- Write latency: MEM_WR is high in the cycle immediately after the B2 handshake.
- CHK: accept one byte.
  - Match: go to DONE.
  - Mismatch: set LOAD_ERR, drop CPU_HOLD, return to IDLE. Words already written are not rolled back.
- DONE (1 cycle): LOAD_DONE=1, CPU_HOLD=0, IN_READY=0, then IDLE.
- IN_READY is 1 only in IDLE, A_LO..C_HI, W0..W2 and CHK. Bytes offered while IN_READY=0 are not consumed. IN_VALID gaps of any length are tolerated in every state.
- SYNC_BYTE inside a frame is treated as ordinary data. Framing is not re-synchronised mid-frame.
- Count semantics: count N = exactly N writes. N = 0 gives no MEM_WR. Maximum N = 4095.
- Reset mid-frame: immediate return to IDLE. CPU_HOLD and MEM_WR drop asynchronously. Partial word is discarded.
- MEM_ADDR/MEM_DATA hold their last values outside WRITE. They are only meaningful while MEM_WR=1.

Test Plan:
- Basic load: send A5 10 00 02 00 45 23 01 FF FF 07 72 -> MEM_WR at 0x010 data 0x12345, then at 0x011 data 0x7FFFF. LOAD_DONE pulses once, CPU_HOLD falls with it, WORDS_WRITTEN=2, LOAD_ERR=0.
- Wrap-around: A5 FF 0F 02 00, words 0x00001 and 0x00002, correct CSUM -> writes at 0xFFF then 0x000, LOAD_DONE.
- Empty frame: A5 00 00 00 00 00 -> no MEM_WR, LOAD_DONE after CSUM, WORDS_WRITTEN=0.
- Bad checksum: basic frame with CSUM 0x73 -> both writes occur, LOAD_ERR=1 and stays set, no LOAD_DONE. A following good frame clears LOAD_ERR at its SYNC.
- Backpressure: IN_VALID toggled randomly and junk bytes 0x00/0x5A before SYNC -> junk ignored, IN_READY=0 exactly during WRITE and DONE cycles, same writes as the basic load.
- Reset mid-load: assert RST after the B1 byte of word 1 -> CPU_HOLD=0 and no MEM_WR for the partial word. A subsequent full frame loads correctly.
